// File: rtl/control_unit_fsm.sv
// Multicycle control FSM for the 64-bit RISC-V datapath.
// Define CTRL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module control_unit_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       ALUSrcA,
  output logic       LoadAOut,
  output logic       RegWrite,
  output logic       LoadRegA,
  output logic       LoadRegB,
  output logic       MemToReg,
  output logic       DMemRead,
  output logic       DMemWrite,
  output logic       LoadMDR,
  output logic       IMemRead,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       pc_load,
  output logic [3:0] state
`ifdef CTRL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9
`ifdef CTRL_TRAP_EN
    ,
    TRAP      = 4'd10
`endif
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_e state_q, state_d;
  // Low until the first edge after reset release; keeps outputs quiet
  logic   run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!run_q) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:     if (imem_ready) state_d = DECODE;
        DECODE: begin
          unique case (1'b1)
            (opcode == OP_R):  state_d = EXEC_R;
            (opcode == OP_I):  state_d = EXEC_I;
            (opcode == OP_LD),
            (opcode == OP_ST): state_d = MEM_ADDR;
            (opcode == OP_BR): state_d = BRANCH;
`ifdef CTRL_TRAP_EN
            default:           state_d = TRAP;
`else
            default:           state_d = FETCH;
`endif
          endcase
        end
        MEM_ADDR:  state_d = (opcode == OP_LD) ? MEM_READ : MEM_WRITE;
        MEM_READ:  if (dmem_ready) state_d = MEM_WB;
        MEM_WB:    state_d = FETCH;
        MEM_WRITE: if (dmem_ready) state_d = FETCH;
        EXEC_R:    state_d = ALU_WB;
        EXEC_I:    state_d = ALU_WB;
        ALU_WB:    state_d = FETCH;
        BRANCH:    state_d = FETCH;
`ifdef CTRL_TRAP_EN
        TRAP:      state_d = TRAP;
`endif
        default:   state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    ALUSrcA     = 1'b0;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 1'b0;
    DMemRead    = 1'b0;
    DMemWrite   = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    if (run_q) begin
      case (state_q)
        FETCH: begin
          IMemRead = 1'b1;
          ALUSrcB  = 2'b01;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = 2'b11;
          LoadAOut = 1'b1;
        end
        MEM_ADDR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          LoadAOut = 1'b1;
        end
        MEM_READ: begin
          DMemRead = 1'b1;
          LoadMDR  = dmem_ready;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEM_WRITE: DMemWrite = 1'b1;
        EXEC_R: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b10;
          LoadAOut = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ALUOp    = 2'b11;
          LoadAOut = 1'b1;
        end
        ALU_WB: RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign pc_load = PCWrite | (PCWriteCond & alu_zero);
  assign state   = state_q;

`ifdef CTRL_TRAP_EN
  // TRAP only exits through reset, so this flag is sticky
  assign illegal_instr = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed self-checking bench for control_unit_fsm.
// Builds with or without CTRL_TRAP_EN.
module tb_control_unit_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_zero, imem_ready, dmem_ready;
  logic       PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite;
  logic       LoadRegA, LoadRegB, MemToReg, DMemRead, DMemWrite;
  logic       LoadMDR, IMemRead, IRWrite, pc_load;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
`ifdef CTRL_TRAP_EN
  logic       illegal_instr;
`endif

  int nchk = 0;
  int nerr = 0;

  control_unit_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA),
    .LoadAOut(LoadAOut), .RegWrite(RegWrite), .LoadRegA(LoadRegA),
    .LoadRegB(LoadRegB), .MemToReg(MemToReg), .DMemRead(DMemRead),
    .DMemWrite(DMemWrite), .LoadMDR(LoadMDR), .IMemRead(IMemRead),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .pc_load(pc_load), .state(state)
`ifdef CTRL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  // PCW PCWC ASA LAO RW LRA LRB M2R DR DW LMDR IMR IRW | PCS ASB AOP
  logic [18:0] flags;
  assign flags = {PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite,
                  LoadRegA, LoadRegB, MemToReg, DMemRead, DMemWrite,
                  LoadMDR, IMemRead, IRWrite, PCSource, ALUSrcB, ALUOp};

  localparam logic [18:0] F_RDY = 19'b1000000000011_00_01_00;
  localparam logic [18:0] F_STL = 19'b0000000000010_00_01_00;
  localparam logic [18:0] DEC   = 19'b0001011000000_00_11_00;
  localparam logic [18:0] MADDR = 19'b0011000000000_00_10_00;
  localparam logic [18:0] MRD_W = 19'b0000000010000_00_00_00;
  localparam logic [18:0] MRD_R = 19'b0000000010100_00_00_00;
  localparam logic [18:0] MWB   = 19'b0000100100000_00_00_00;
  localparam logic [18:0] MWR   = 19'b0000000001000_00_00_00;
  localparam logic [18:0] EXR   = 19'b0011000000000_00_00_10;
  localparam logic [18:0] EXI   = 19'b0011000000000_00_10_11;
  localparam logic [18:0] AWB   = 19'b0000100000000_00_00_00;
  localparam logic [18:0] BR    = 19'b0110000000000_01_00_01;
  localparam logic [18:0] ZERO  = 19'b0;

  task automatic chk_now(input string tag, input logic [3:0] st,
                         input logic [18:0] fl);
    nchk++;
    assert (state === st) else begin
      nerr++;
      $error("FAIL %s state got %0d exp %0d", tag, state, st);
    end
    nchk++;
    assert (flags === fl) else begin
      nerr++;
      $error("FAIL %s flags got %b exp %b", tag, flags, fl);
    end
  endtask

  task automatic chk_pc(input string tag, input logic exp);
    nchk++;
    assert (pc_load === exp) else begin
      nerr++;
      $error("FAIL %s pc_load got %b exp %b", tag, pc_load, exp);
    end
  endtask

  // Sample mid-cycle, then advance to the next falling edge
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [18:0] fl);
    #1;
    chk_now(tag, st, fl);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    opcode     = 7'b0110011;
    alu_zero   = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    chk_now("rst_hold", 4'd0, ZERO);
    chk_pc("rst_pc", 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc("rst_rel", 4'd0, ZERO);

    // R-type
    cyc("r_fetch", 4'd0, F_RDY);
    cyc("r_dec", 4'd1, DEC);
    cyc("r_exec", 4'd6, EXR);
    cyc("r_wb", 4'd8, AWB);

    // I-type
    opcode = 7'b0010011;
    cyc("i_fetch", 4'd0, F_RDY);
    cyc("i_dec", 4'd1, DEC);
    cyc("i_exec", 4'd7, EXI);
    cyc("i_wb", 4'd8, AWB);

    // Load with 3 stall cycles in MEM_READ
    opcode = 7'b0000011;
    cyc("ld_fetch", 4'd0, F_RDY);
    cyc("ld_dec", 4'd1, DEC);
    dmem_ready = 1'b0;
    cyc("ld_addr", 4'd2, MADDR);
    cyc("ld_wait0", 4'd3, MRD_W);
    cyc("ld_wait1", 4'd3, MRD_W);
    cyc("ld_wait2", 4'd3, MRD_W);
    dmem_ready = 1'b1;
    cyc("ld_rdy", 4'd3, MRD_R);
    cyc("ld_wb", 4'd4, MWB);

    // BEQ taken, then not taken
    opcode = 7'b1100011;
    #1;
    chk_pc("br1_fetch_pc", 1'b1);
    cyc("br1_fetch", 4'd0, F_RDY);
    cyc("br1_dec", 4'd1, DEC);
    alu_zero = 1'b1;
    #1;
    chk_pc("br1_taken_pc", 1'b1);
    cyc("br1_br", 4'd9, BR);
    alu_zero = 1'b0;
    cyc("br2_fetch", 4'd0, F_RDY);
    cyc("br2_dec", 4'd1, DEC);
    #1;
    chk_pc("br2_nt_pc", 1'b0);
    cyc("br2_br", 4'd9, BR);

    // FETCH stalls on imem_ready; stray dmem_ready is ignored
    opcode     = 7'b0110011;
    imem_ready = 1'b0;
    #1;
    chk_pc("f_stall_pc", 1'b0);
    cyc("f_stall0", 4'd0, F_STL);
    cyc("f_stall1", 4'd0, F_STL);
    imem_ready = 1'b1;
    cyc("f_go", 4'd0, F_RDY);
    cyc("f_dec", 4'd1, DEC);
    cyc("f_exec", 4'd6, EXR);
    cyc("f_wb", 4'd8, AWB);

    // Store, async reset while waiting in MEM_WRITE
    opcode = 7'b0100011;
    cyc("st_fetch", 4'd0, F_RDY);
    cyc("st_dec", 4'd1, DEC);
    dmem_ready = 1'b0;
    cyc("st_addr", 4'd2, MADDR);
    cyc("st_wait", 4'd5, MWR);
    #1;
    chk_now("st_hold", 4'd5, MWR);
    reset = 1'b0;
    #1;
    chk_now("st_async_rst", 4'd0, ZERO);
    @(negedge clk);
    reset      = 1'b1;
    dmem_ready = 1'b1;
    cyc("st_rel", 4'd0, ZERO);

    // Store with readies high: 4 cycles
    cyc("st2_fetch", 4'd0, F_RDY);
    cyc("st2_dec", 4'd1, DEC);
    cyc("st2_addr", 4'd2, MADDR);
    cyc("st2_wr", 4'd5, MWR);

    // Unknown opcode
    opcode = 7'b1111111;
    cyc("ill_fetch", 4'd0, F_RDY);
    cyc("ill_dec", 4'd1, DEC);
`ifdef CTRL_TRAP_EN
    #1;
    nchk++;
    assert (illegal_instr === 1'b1) else begin
      nerr++;
      $error("FAIL ill_flag got %b exp 1", illegal_instr);
    end
    cyc("ill_trap0", 4'd10, ZERO);
    opcode = 7'b0110011;
    cyc("ill_trap1", 4'd10, ZERO);
    cyc("ill_trap2", 4'd10, ZERO);
    reset = 1'b0;
    #1;
    nchk++;
    assert (illegal_instr === 1'b0) else begin
      nerr++;
      $error("FAIL ill_clr got %b exp 0", illegal_instr);
    end
    chk_now("ill_rst", 4'd0, ZERO);
    @(negedge clk);
    reset = 1'b1;
    cyc("ill_rel", 4'd0, ZERO);
    cyc("ill_fetch2", 4'd0, F_RDY);
`else
    opcode = 7'b0110011;
    cyc("ill_nop", 4'd0, F_RDY);
    cyc("ill_dec2", 4'd1, DEC);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
# control_unit_fsm

Multicycle control state machine for the 64-bit RISC-V datapath. It decodes the instruction-register opcode and sequences every datapath control flag across fetch, decode, execute, memory and write-back, one state per cycle. It stalls on instruction- and data-memory ready handshakes. It sits beside the datapath top level and drives all of that top level's control inputs.

## Interface
Parameters:
- none; flag encodings are fixed by the datapath.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; asserting it forces state FETCH and all outputs 0
- opcode  in  7  instruction-register bits [6:0]
- alu_zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access completes this cycle
- PCWrite, PCWriteCond, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, DMemRead, DMemWrite, LoadMDR, IMemRead, IRWrite  out  1 each  datapath control flags
- PCSource, ALUSrcB, ALUOp  out  2 each  datapath selects
- pc_load  out  1  PCWrite | (PCWriteCond & alu_zero)
- state  out  4  current state, for debug
- illegal_instr  out  1  sticky trap flag; present only with CTRL_TRAP_EN

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=10.
- Outputs decode from state. Only FETCH, MEM_READ and MEM_WRITE also use a ready input. Any flag not listed for a state is 0.
- FETCH: IMemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite equal imem_ready. Holds until imem_ready, then goes to DECODE.
- DECODE: LoadRegA=LoadRegB=1, ALUSrcA=0, ALUSrcB=11, ALUOp=00, LoadAOut=1. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other -> FETCH, or TRAP with CTRL_TRAP_EN
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, LoadAOut=1. Goes to MEM_READ on a load opcode, else MEM_WRITE.
- MEM_READ: DMemRead=1, LoadMDR=dmem_ready. Holds until dmem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1. Next: FETCH.
- MEM_WRITE: DMemWrite=1. Holds until dmem_ready, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, LoadAOut=1. Next: ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11, LoadAOut=1. Next: ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- opcode is sampled in DECODE and MEM_ADDR only. The instruction register is stable there because IRWrite=0 outside FETCH.

## Timing
- Reset is asynchronous: state becomes FETCH and all outputs 0 immediately, mid-instruction included. The first FETCH outputs appear the cycle after deassertion.
- Cycle counts with ready inputs held high:
  - R, I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - illegal without the macro: 2 cycles
- Each cycle imem_ready or dmem_ready is low in its wait state adds exactly one cycle. Outputs hold stable during a stall.
- A ready input asserted outside its wait state is ignored.
- pc_load is combinational, in the same cycle as alu_zero.

## Configuration
- CTRL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP drives all flags 0 and sets illegal_instr=1.
  - TRAP is held until reset; illegal_instr clears only on reset.
- CTRL_TRAP_EN undefined:
  - The TRAP state and the illegal_instr port do not exist.
  - An unknown opcode returns to FETCH as a NOP. The PC has already advanced by 4.

## Test plan
- R-type, opcode 0110011, readies high -> state sequence 0,1,6,8,0; RegWrite=1 only in state 8; IRWrite=PCWrite=1 only in cycle 0.
- Load, opcode 0000011, dmem_ready low 3 cycles in MEM_READ -> 8 cycles total; LoadMDR=1 only in the ready cycle; MemToReg=1 in MEM_WB.
- BEQ with alu_zero=1 then alu_zero=0 in BRANCH -> pc_load=1 then 0; PCSource=01 both times.
- FETCH with imem_ready low 2 cycles -> stays in state 0; IRWrite=0 for 2 cycles, then 1 for one cycle.
- Reset pulled low while in MEM_WRITE -> state=0 and DMemWrite=0 immediately, without waiting for clk.
- Opcode 1111111 -> with CTRL_TRAP_EN: state 10, illegal_instr=1, held until reset; without it: state 0 after DECODE.
